ps2_rx: RTL and testbench

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx.sv | 178 +++++++++++++++++
 tb/tb_ps2_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver.
// The asynchronous ps2_clk/ps2_data lines are synchronized first. ps2_clk is then
// glitch-filtered, and each falling edge of the filtered clock makes a one-cycle
// strobe. On each strobe the receiver samples ps2_data and steps through one
// 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ps2_data,
  input  logic       ps2_clk,
  input  logic       rd,
  output logic [7:0] data,
  output logic       rda,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // True when the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic          r_clk_s1;
  logic          r_clk_s2;
  logic          r_dat_s1;
  logic          r_dat_s2;
  logic          r_filt;
  logic          r_filt_d;
  logic [FW-1:0] r_filt_cnt;
  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_data;
  logic          r_rda;
  logic          r_perr;
  logic          r_ferr;
  logic          r_ovr;
  logic          w_strobe;

  // Two-flop synchronizers for both PS/2 lines; they reset to the idle-high bus level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: the filtered clock follows the synchronized clock only after
  // FILTER_LEN consecutive samples that differ from the current filtered level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 != r_filt) begin
        if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
          r_filt     <= r_clk_s2;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + {{(FW-1){1'b0}}, 1'b1};
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_strobe = r_filt_d & ~r_filt;

  // Frame FSM, inter-edge timeout, and the registered consumer-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      r_data    <= 8'h00;
      r_rda     <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      // A read clears the available flag; a delivery further down overrides this.
      if (rd && r_rda) begin
        r_rda <= 1'b0;
        r_ovr <= 1'b0;
      end else begin
        r_rda <= r_rda;
        r_ovr <= r_ovr;
      end

      if (!en) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        r_to_cnt  <= '0;
      end else if (w_strobe) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            r_data  <= r_shift;
            r_rda   <= 1'b1;
            r_perr  <= ~odd_parity_ok(r_shift, r_par);
            r_ferr  <= ~r_dat_s2;
            r_ovr   <= rd ? 1'b0 : (r_rda | r_ovr);
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_to_cnt == TW'(TIMEOUT_CYC)) begin
          r_state  <= S_IDLE;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + {{(TW-1){1'b0}}, 1'b1};
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign data       = r_data;
  assign rda        = r_rda;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frames are driven at bit level, and the expected
// delivery is queued. A monitor pops the queue whenever rda or overrun rises.
module tb_ps2_rx;
  localparam int FL   = 4;
  localparam int TO   = 300;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ps2_data = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       rda;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  logic m_rda = 1'b0;
  logic m_ovr = 1'b0;
  logic mon_prev_r = 1'b0;
  logic mon_prev_o = 1'b0;
  exp_t mon_e;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .ps2_data(ps2_data), .ps2_clk(ps2_clk), .rd(rd),
    .data(data), .rda(rda), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic do_rd();
    rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
    m_rda = 1'b0;
    m_ovr = 1'b0;
  endtask

  // rd_mode: 0 = no read, 1 = rd on the delivery cycle, 2 = rd three cycles after rda rises.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit lat_chk, input int rd_mode);
    exp_t e;
    logic was_rda;
    logic was_ovr;
    int   used;
    was_rda = m_rda;
    was_ovr = m_ovr;
    e.d  = d;
    e.pe = (($countones({d, par}) % 2) == 0);
    e.fe = (stop == 1'b0);
    e.ov = (rd_mode == 1) ? 1'b0 : (m_rda | m_ovr);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    if (!was_rda || (e.ov && !was_ovr)) sb.push_back(e);
    m_rda = 1'b1;
    m_ovr = e.ov;
    ps2_data = stop;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    // rda is expected 2 sync + FL filter + 1 delivery cycles after the falling drive.
    wait_cyc(2 + FL);
    if (lat_chk && !was_rda) check("latency_pre", rda, 1'b0);
    if (rd_mode == 1) rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
    used = 3 + FL;
    if (lat_chk && !was_rda) check("latency_rise", rda, 1'b1);
    if (rd_mode == 2) begin
      wait_cyc(3);
      check("rda_before_rd", rda, 1'b1);
      rd = 1'b1;
      wait_cyc(1);
      rd = 1'b0;
      check("rd_clears_rda", rda, 1'b0);
      check("rd_clears_ovr", overrun, 1'b0);
      m_rda = 1'b0;
      m_ovr = 1'b0;
      used = used + 4;
    end
    wait_cyc(HALF - used);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  // Monitor: each rising rda or overrun is one delivery; compare it against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mon_prev_r = 1'b0;
        mon_prev_o = 1'b0;
      end else begin
        if ((rda && !mon_prev_r) || (overrun && !mon_prev_o)) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got data %0h expected no delivery", data);
          end else begin
            mon_e = sb.pop_front();
            check("sb_data", data, mon_e.d);
            check("sb_parity_err", parity_err, mon_e.pe);
            check("sb_frame_err", frame_err, mon_e.fe);
            check("sb_overrun", overrun, mon_e.ov);
          end
        end
        mon_prev_r = rda;
        mon_prev_o = overrun;
      end
    end
  end

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rdat;
    logic       rpar;
    logic       rstop;
    int         rmode;

    // Reset state.
    wait_cyc(5);
    check("rst_data", data, 8'h00);
    check("rst_rda", rda, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b1;
    en  = 1'b1;
    wait_cyc(20);

    // Good frame with latency check, then rd three cycles after rda rises.
    send_frame(8'hED, 1'b1, 1'b1, 1'b1, 2);

    // Parity error, then a stop error that also overruns.
    send_frame(8'hAA, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 0);
    do_rd();
    wait_cyc(10);

    // Partial frame abandoned by timeout, then a clean frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    wait_cyc(2 * TO);
    check("timeout_no_rda", rda, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 0);

    // rd on the exact delivery cycle while rda is already set.
    send_frame(8'h3B, 1'b0, 1'b1, 1'b0, 1);
    check("rd_deliv_data", data, 8'h3B);
    check("rd_deliv_rda", rda, 1'b1);
    check("rd_deliv_ovr", overrun, 1'b0);
    do_rd();

    // Short low glitch on ps2_clk with data low must not start a frame.
    ps2_data = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
    wait_cyc(50);
    send_frame(8'h12, 1'b1, 1'b1, 1'b1, 0);

    // Reset in the middle of a frame, then a full frame.
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(((8'hF0 >> i) & 8'h01) != 8'h00);
    rst = 1'b0;
    m_rda = 1'b0;
    m_ovr = 1'b0;
    wait_cyc(4);
    check("midrst_data", data, 8'h00);
    check("midrst_rda", rda, 1'b0);
    check("midrst_perr", parity_err, 1'b0);
    check("midrst_ferr", frame_err, 1'b0);
    check("midrst_ovr", overrun, 1'b0);
    rst = 1'b1;
    wait_cyc(20);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b1, 0);
    check("after_rst_data", data, 8'hF0);
    check("after_rst_rda", rda, 1'b1);
    do_rd();

    // Disable mid-frame: the partial frame is dropped and the outputs hold.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    en = 1'b0;
    wait_cyc(100);
    check("en_hold_data", data, 8'hF0);
    check("en_hold_rda", rda, 1'b0);
    en = 1'b1;
    wait_cyc(20);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b1, 0);

    // Randomized frames with random reads.
    for (int n = 0; n < 10; n++) begin
      if (m_ovr) do_rd();
      rdat  = 8'($urandom_range(0, 255));
      rpar  = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 4) != 0);
      rmode = $urandom_range(0, 2);
      send_frame(rdat, rpar, rstop, 1'b1, rmode);
      if ($urandom_range(0, 1) == 1) do_rd();
    end

    wait_cyc(100);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
